// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between instruction fetch (reads only) and the
//   load/store unit (reads and writes). At most one access is in flight. Read data
//   comes back from memory one cycle after acceptance and is routed to the owner.
//   The LSU has priority. A saturating starvation counter forces a fetch grant
//   after STARVE_LIMIT consecutive LSU grants while fetch is waiting. A fetch
//   response is suppressed if a flush arrives in its accept or response cycle.
//
// Ports
//   clk_i, rst_ni                 clock; synchronous active-low reset
//   if_req_valid_i/addr_i/ready_o fetch request channel
//   if_flush_i                    kills the pending fetch response
//   if_rsp_valid_o/addr_o/instr_o fetch response (PC and instruction)
//   ls_req_valid_i/we_i/be_i/
//     addr_i/wdata_i/ready_o      LSU request channel
//   ls_rsp_valid_o/rdata_o        LSU response (read data, or 0 for a write ack)
//   mem_req_o/we_o/be_o/addr_o/
//     wdata_o, mem_ready_i        memory request channel
//   mem_rdata_i                   memory read data, one cycle after acceptance
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                if_req_valid_i,
    input  logic [ADDR_W-1:0]   if_req_addr_i,
    output logic                if_req_ready_o,
    input  logic                if_flush_i,
    output logic                if_rsp_valid_o,
    output logic [ADDR_W-1:0]   if_rsp_addr_o,
    output logic [DATA_W-1:0]   if_rsp_instr_o,
    input  logic                ls_req_valid_i,
    input  logic                ls_req_we_i,
    input  logic [DATA_W/8-1:0] ls_req_be_i,
    input  logic [ADDR_W-1:0]   ls_req_addr_i,
    input  logic [DATA_W-1:0]   ls_req_wdata_i,
    output logic                ls_req_ready_o,
    output logic                ls_rsp_valid_o,
    output logic [DATA_W-1:0]   ls_rsp_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_ready_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

    typedef enum logic [1:0] {StIdle, StIfInfl, StLsInfl} state_e;

    state_e            state_q;
    logic [CntW-1:0]   starve_cnt_q;
    logic              flush_pend_q;
    logic [ADDR_W-1:0] if_addr_q;
    logic              ls_we_q;

    logic if_win, ls_win, if_accept, ls_accept;

    // Grant. Gating with rst_ni keeps every request-side output low during reset.
    always_comb begin
        if_win    = rst_ni & if_req_valid_i & (~ls_req_valid_i | (starve_cnt_q == CntMax));
        ls_win    = rst_ni & ls_req_valid_i & ~if_win;
        if_accept = if_win & mem_ready_i;
        ls_accept = ls_win & mem_ready_i;

        if_req_ready_o = if_accept;
        ls_req_ready_o = ls_accept;
        mem_req_o      = if_win | ls_win;

        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (if_win) begin
            mem_be_o   = '1;
            mem_addr_o = if_req_addr_i;
        end else if (ls_win) begin
            mem_we_o    = ls_req_we_i;
            mem_be_o    = ls_req_we_i ? ls_req_be_i : '1;
            mem_addr_o  = ls_req_addr_i;
            mem_wdata_o = ls_req_wdata_i;
        end
    end

    // Responses come straight off the memory data bus in the cycle after accept.
    always_comb begin
        if_rsp_valid_o = 1'b0;
        if_rsp_addr_o  = '0;
        if_rsp_instr_o = '0;
        ls_rsp_valid_o = 1'b0;
        ls_rsp_rdata_o = '0;
        if (rst_ni && state_q == StIfInfl) begin
            if_rsp_valid_o = ~(flush_pend_q | if_flush_i);
            if_rsp_addr_o  = if_addr_q;
            if_rsp_instr_o = mem_rdata_i;
        end
        if (rst_ni && state_q == StLsInfl) begin
            ls_rsp_valid_o = 1'b1;
            ls_rsp_rdata_o = ls_we_q ? '0 : mem_rdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            starve_cnt_q <= '0;
            flush_pend_q <= 1'b0;
            if_addr_q    <= '0;
            ls_we_q      <= 1'b0;
        end else begin
            // The in-flight slot always drains in one cycle; the new owner is
            // whoever was accepted this cycle.
            if (if_accept) begin
                state_q   <= StIfInfl;
                if_addr_q <= if_req_addr_i;
            end else if (ls_accept) begin
                state_q <= StLsInfl;
                ls_we_q <= ls_req_we_i;
            end else begin
                state_q <= StIdle;
            end

            // A flush in the accept cycle must outlive the response slot it would
            // otherwise be cleared by, so the set takes precedence.
            if (if_accept && if_flush_i) begin
                flush_pend_q <= 1'b1;
            end else if (state_q == StIfInfl) begin
                flush_pend_q <= 1'b0;
            end

            if (if_accept || !if_req_valid_i) begin
                starve_cnt_q <= '0;
            end else if (ls_accept && starve_cnt_q != CntMax) begin
                starve_cnt_q <= starve_cnt_q + CntW'(1);
            end
        end
    end

endmodule
